// File: rtl/fifo_rd_stream_pkg.sv
// -----------------------------------------------------------------------------
// fifo_rd_stream_pkg
// Shared constants and helpers for the FIFO read-side stream adapter.
// Holds the prefetch depth and the pointer/occupancy widths used by both the
// control logic in fifo_rd_stream and the slot storage in fifo_rd_slots.
// -----------------------------------------------------------------------------
package fifo_rd_stream_pkg;

    // Number of prefetch slots; sized to cover the one-cycle FIFO read latency
    // while still sustaining one word per cycle without a ready->rd_en path.
    localparam int PREFETCH_DEPTH = 3;

    // Slot index width (0..2) and occupancy width (0..3).
    localparam int PTR_WIDTH = 2;
    localparam int OCC_WIDTH = 2;

    typedef logic [PTR_WIDTH-1:0] ptr_t;
    typedef logic [OCC_WIDTH-1:0] occ_t;

    // Advance a slot pointer, wrapping from the last slot back to slot 0.
    function automatic ptr_t ptr_inc(input ptr_t p);
        ptr_t r;
        if (p == ptr_t'(PREFETCH_DEPTH - 1)) begin
            r = '0;
        end else begin
            r = p + ptr_t'(1);
        end
        return r;
    endfunction

endpackage : fifo_rd_stream_pkg

// File: rtl/fifo_rd_slots.sv
// -----------------------------------------------------------------------------
// fifo_rd_slots
// Prefetch storage for fifo_rd_stream: a small register file with one
// synchronous write port (landing data at the tail) and one asynchronous read
// port (head of the buffer, driven straight onto the stream payload).
// Contents are not reset; the control logic never presents a slot it has not
// written since reset.
// -----------------------------------------------------------------------------
module fifo_rd_slots
    import fifo_rd_stream_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  i_clk,
    input  logic                  i_wr_en,
    input  ptr_t                  i_wr_ptr,
    input  logic [DATA_WIDTH-1:0] i_wr_data,
    input  ptr_t                  i_rd_ptr,
    output logic [DATA_WIDTH-1:0] o_rd_data
);

    logic [DATA_WIDTH-1:0] r_slot [PREFETCH_DEPTH];

    // Capture the landing word into the tail slot.
    always_ff @(posedge i_clk) begin
        if (i_wr_en) begin
            r_slot[i_wr_ptr] <= i_wr_data;
        end
    end

    // Head slot is read combinationally; its source is a register, so the
    // payload is glitch-free with respect to the consumer's ready.
    assign o_rd_data = r_slot[i_rd_ptr];

endmodule : fifo_rd_slots

// File: rtl/fifo_rd_stream.sv
// -----------------------------------------------------------------------------
// fifo_rd_stream
// Read-side adapter for a FIFO with a registered read port (data returns one
// cycle after the read strobe). A three-slot prefetch buffer hides that
// latency and presents a valid/ready stream at one word per cycle.
//
// The read strobe is computed only from local registers and i_fifo_empty, so
// there is no combinational path from i_out_ready to o_fifo_rd_en. A read is
// issued only while buffered + in-flight words leave a free slot, which
// guarantees every returning word has somewhere to land.
//
// Optional feature macro: FIFO_RD_STREAM_CNT_EN
//   defined   : o_xfer_cnt counts accepted words, wrapping at 2^CNT_WIDTH.
//   undefined : no counter register, o_xfer_cnt is tied to zero.
//
// The upstream FIFO must share i_rst_n so that words in flight at reset are
// discarded on both sides together.
// -----------------------------------------------------------------------------
module fifo_rd_stream
    import fifo_rd_stream_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_fifo_empty,
    output logic                  o_fifo_rd_en,
    input  logic [DATA_WIDTH-1:0] i_fifo_dout,
    output logic                  o_out_valid,
    output logic [DATA_WIDTH-1:0] o_out_data,
    input  logic                  i_out_ready,
    output logic [CNT_WIDTH-1:0]  o_xfer_cnt
);

    logic                  r_inflight;
    occ_t                  r_count;
    ptr_t                  r_head;
    ptr_t                  r_tail;

    logic [OCC_WIDTH:0]    w_occupancy;
    logic                  w_rd_en;
    logic                  w_out_valid;
    logic                  w_pop;
    logic [DATA_WIDTH-1:0] w_head_data;

    // Words already buffered plus the one (at most) still returning from the FIFO.
    always_comb begin
        w_occupancy = {1'b0, r_count} + {{OCC_WIDTH{1'b0}}, r_inflight};
    end

    // Issue a read when the FIFO has data and a slot is guaranteed free on landing.
    always_comb begin
        w_rd_en = i_rst_n & ~i_fifo_empty
                & (w_occupancy < (OCC_WIDTH+1)'(PREFETCH_DEPTH));
    end

    // Stream handshake; ready with an empty buffer does not pop.
    always_comb begin
        w_out_valid = (r_count != '0);
        w_pop       = w_out_valid & i_out_ready;
    end

    // Track the outstanding FIFO read so its data is sampled exactly once.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_inflight <= 1'b0;
        end else begin
            r_inflight <= w_rd_en;
        end
    end

    // Tail advances whenever returning data lands in the buffer.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_tail <= '0;
        end else if (r_inflight) begin
            r_tail <= ptr_inc(r_tail);
        end
    end

    // Head advances on every accepted transfer.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_head <= '0;
        end else if (w_pop) begin
            r_head <= ptr_inc(r_head);
        end
    end

    // Occupancy: +1 on landing, -1 on pop; land and pop together cancel.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_count <= '0;
        end else begin
            r_count <= r_count + occ_t'(r_inflight) - occ_t'(w_pop);
        end
    end

    fifo_rd_slots #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_slots (
        .i_clk      (i_clk),
        .i_wr_en    (r_inflight),
        .i_wr_ptr   (r_tail),
        .i_wr_data  (i_fifo_dout),
        .i_rd_ptr   (r_head),
        .o_rd_data  (w_head_data)
    );

`ifdef FIFO_RD_STREAM_CNT_EN
    logic [CNT_WIDTH-1:0] r_xfer_cnt;

    // Count accepted words; wraps naturally at the counter width.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_xfer_cnt <= '0;
        end else if (w_pop) begin
            r_xfer_cnt <= r_xfer_cnt + CNT_WIDTH'(1);
        end
    end

    assign o_xfer_cnt = r_xfer_cnt;
`else
    assign o_xfer_cnt = '0;
`endif

    assign o_fifo_rd_en = w_rd_en;
    assign o_out_valid  = w_out_valid;
    assign o_out_data   = w_head_data;

endmodule : fifo_rd_stream
